// File: rtl/dfram_rd_streamer.sv
// dfram_rd_streamer: issues LEN wrapping DFRAM reads from BASE and streams the returned data
// out as a credit-limited valid/ready burst with a last flag.
module dfram_rd_streamer #(
   parameter int DW     = 128,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH),
   parameter int LW     = AW + 1,
   parameter int FDEPTH = 4,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [LW-1:0] len,
   output logic          ready_o,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   input  logic          rd_valid,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);
   localparam int FAW = $clog2(FDEPTH);
   localparam int SW  = $clog2(RD_LAT) + 1;

   typedef enum logic [1:0] {SETTLE, IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [SW-1:0] settle_cnt;
   logic [AW-1:0] addr;
   logic [LW-1:0] issue_cnt, beat_cnt;
   logic [FAW:0]  inflight, fifo_cnt;
   logic [FAW-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] fifo [FDEPTH];
   logic          accept, issue, push, pop, finish;

   assign m_valid = fifo_cnt != '0;
   assign m_data  = fifo[rd_ptr];
   assign m_last  = m_valid && beat_cnt == LW'(1);
   assign pop     = m_valid && m_ready;
   // responses only count when a read is outstanding; anything else is stale or spurious
   assign push    = rd_valid && inflight != '0;
   assign rd_req  = issue;
   assign rd_addr = issue ? addr : '0;

   always_ff @(posedge clk) state <= rst ? SETTLE : state_nx;

   always_comb begin
      ready_o  = state == IDLE;
      busy     = state == RUN;
      accept   = ready_o && start && len != '0;
      issue    = busy && issue_cnt != '0 && ({1'b0, fifo_cnt} + {1'b0, inflight} < (FAW+2)'(FDEPTH));
      finish   = busy && pop && beat_cnt == LW'(1);
      state_nx = state == SETTLE ? (settle_cnt == SW'(RD_LAT-1) ? IDLE : SETTLE)
               : accept ? RUN : finish ? IDLE : state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         addr       <= '0;
         issue_cnt  <= '0;
         beat_cnt   <= '0;
         inflight   <= '0;
         fifo_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
         done       <= (ready_o && start && len == '0) || finish;
         err        <= err || (rd_valid && inflight == '0 && state != SETTLE);
         inflight   <= inflight + (FAW+1)'(issue) - (FAW+1)'(push);
         fifo_cnt   <= fifo_cnt + (FAW+1)'(push) - (FAW+1)'(pop);
         if (push) wr_ptr <= wr_ptr + FAW'(1);
         if (pop) rd_ptr <= rd_ptr + FAW'(1);
         if (accept) begin
            addr      <= base;
            issue_cnt <= len;
            beat_cnt  <= len;
         end else begin
            if (issue) begin
               addr      <= addr == AW'(DEPTH-1) ? '0 : addr + AW'(1);
               issue_cnt <= issue_cnt - LW'(1);
            end
            if (pop) beat_cnt <= beat_cnt - LW'(1);
         end
      end
   end

   always_ff @(posedge clk) if (push) fifo[wr_ptr] <= rd_data;
endmodule

// File: tb/tb_dfram_rd_streamer.sv
// tb_dfram_rd_streamer: randomized scoreboard bench; a DFRAM model answers reads after RD_LAT
// cycles and expected beats/addresses come from base+k modulo DEPTH.
module tb_dfram_rd_streamer;
   localparam int DW = 128, DEPTH = 1024, AW = 10, LW = 11, FDEPTH = 4, RD_LAT = 2;

   typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;

   logic clk = 0, rst = 1, start = 0, m_ready = 0, inj = 0;
   logic [AW-1:0] base = '0;
   logic [LW-1:0] len = '0;
   logic ready_o, busy, done, err, rd_req, rd_valid, m_valid, m_last;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, m_data;

   always #5 clk = ~clk;

   dfram_rd_streamer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LW(LW), .FDEPTH(FDEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .ready_o(ready_o), .busy(busy),
      .done(done), .err(err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

   // DFRAM model: fixed-latency read pipe, deliberately not reset so stale responses occur
   logic [DW-1:0] mem [DEPTH];
   logic [RD_LAT-1:0] pv = '0;
   logic [DW-1:0] pd [RD_LAT];
   always @(posedge clk) begin
      pv <= {pv[RD_LAT-2:0], rd_req};
      pd[0] <= mem[rd_addr];
      for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
   end
   assign rd_valid = pv[RD_LAT-1] | inj;
   assign rd_data  = pd[RD_LAT-1];

   int checks = 0, errors = 0, cyc = 0, rd_req_cnt = 0, outstanding = 0, mode = 0;
   beat_t exp_q[$];
   logic [AW-1:0] addr_q[$];
   int hs_cyc[$];
   bit done_pend = 0, zero_start = 0, stall_prev = 0;
   logic [DW-1:0] stall_d;

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic flag(string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // m_ready: mode 0 = always ready, 1 = stalled, 2 = random 50%
   initial forever begin
      @(posedge clk);
      #1 m_ready = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 0;
   end

   always @(negedge clk) begin
      beat_t b;
      cyc++;
      if (rst) begin
         exp_q.delete();
         addr_q.delete();
         done_pend = 0;
         zero_start = 0;
         stall_prev = 0;
         outstanding = 0;
      end else begin
         chk("done", done, done_pend);
         done_pend = 0;
         if (zero_start) begin
            done_pend = 1;
            zero_start = 0;
         end
         if (stall_prev) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, stall_d);
         end
         stall_prev = m_valid && !m_ready;
         stall_d = m_data;
         if (rd_req) begin
            rd_req_cnt++;
            outstanding++;
            chk("credit", outstanding <= FDEPTH, 1);
            if (addr_q.size() == 0) flag("rd_req_extra");
            else chk("rd_addr", rd_addr, addr_q.pop_front());
         end
         if (m_valid && m_ready) begin
            outstanding--;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) flag("beat_extra");
            else begin
               b = exp_q.pop_front();
               chk("m_data", m_data, b.data);
               chk("m_last", m_last, b.last);
               if (b.last) done_pend = 1;
            end
         end
      end
   end

   task automatic xfer(int b, int n);
      @(posedge clk);
      #1 start = 1;
      base = AW'(b);
      len = LW'(n);
      for (int k = 0; k < n; k++) begin
         logic [AW-1:0] a;
         a = AW'((b + k) % DEPTH);
         addr_q.push_back(a);
         exp_q.push_back('{data: mem[a], last: k == n - 1});
      end
      if (n == 0) zero_start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (ready_o && exp_q.size() == 0 && addr_q.size() == 0) begin
            repeat (2) @(negedge clk);
            return;
         end
      end
      flag("timeout_idle");
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_reset_outs(string name);
      chk(name, {rd_req, rd_addr, m_valid, m_last, busy, done, err, ready_o}, '0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset_outs");
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < RD_LAT; i++) begin
         @(negedge clk);
         chk("settle_ready", ready_o, 0);
      end
      @(negedge clk);
      chk("idle_ready", ready_o, 1);

      // T1: mem[i]=i, consecutive beats
      mode = 0;
      hs_cyc.delete();
      xfer(0, 8);
      wait_idle();
      chk("t1_beats", hs_cyc.size(), 8);
      for (int k = 1; k < hs_cyc.size(); k++) chk("t1_consecutive", hs_cyc[k] - hs_cyc[0], k);

      // T2: wrap through 0
      randomize_mem();
      xfer(1022, 4);
      wait_idle();

      // T3: stalled sink, only FDEPTH reads may be issued
      mode = 1;
      rd_req_cnt = 0;
      xfer($urandom_range(0, DEPTH - 1), 16);
      repeat (20) @(negedge clk);
      chk("t3_issued", rd_req_cnt, FDEPTH);
      chk("t3_busy", busy, 1);
      mode = 0;
      wait_idle();

      // T4: random back-pressure and random transfers
      mode = 2;
      xfer($urandom_range(0, DEPTH - 1), 32);
      wait_idle();
      for (int t = 0; t < 5; t++) begin
         mode = $urandom_range(0, 1) ? 2 : 0;
         xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 40));
         wait_idle();
      end

      // T5: zero length, then start while busy
      mode = 0;
      rd_req_cnt = 0;
      xfer(5, 0);
      repeat (3) @(negedge clk);
      chk("t5_no_req", rd_req_cnt, 0);
      mode = 2;
      xfer(200, 12);
      repeat (3) @(posedge clk);
      #1 start = 1;
      base = 7;
      len = 3;
      @(posedge clk);
      #1 start = 0;
      wait_idle();

      // full-depth transfer from a random base
      mode = 0;
      xfer($urandom_range(0, DEPTH - 1), DEPTH);
      wait_idle();

      // T6: reset mid-transfer, stale responses arrive during settle
      xfer(0, 8);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outs("t6_reset_outs");
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < RD_LAT + 1; i++) begin
         @(negedge clk);
         chk("t6_settle_valid", m_valid, 0);
         chk("t6_settle_err", err, 0);
      end
      chk("t6_ready", ready_o, 1);
      xfer(100, 2);
      wait_idle();

      // spurious rd_valid while idle sets sticky err; reset clears it
      @(posedge clk);
      #1 inj = 1;
      @(posedge clk);
      #1 inj = 0;
      repeat (3) @(negedge clk);
      chk("err_set", err, 1);
      chk("err_no_push", m_valid, 0);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("err_cleared", err, 0);
      repeat (RD_LAT + 1) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
